control_dispensado: RTL and testbench
=====================================

# control_dispensado

Sequencing controller for the coffee-machine datapath. On a start request it latches the requested drink and walks the fixed ingredient order: water, coffee, milk, chocolate, sugar. For each ingredient it presents the ingredient code and drink to the time-selection stage and reads back that stage's 2-bit time class. It then opens the matching valve for the selected number of clock cycles, or skips the ingredient. When the sequence completes it pulses `listo`.

## Interface
Parameters:
- `TICKS_CORTO`, default 2: valve-open cycles for time class 2'b00.
- `TICKS_MEDIO`, default 4: valve-open cycles for time class 2'b01.
- `TICKS_LARGO`, default 8: valve-open cycles for time class 2'b10.
- `CNT_W`, default 8: duration counter width. Every TICKS_* value is ≥1 and ≤2^CNT_W−1.

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — reset, synchronous and active-high.
- `inicio`  in  1  — start request, sampled only in IDLE.
- `cancelar`  in  1  — abort the running sequence.
- `bebida_in`  in  4  — drink request, one-hot: [0] espresso, [1] café con leche, [2] capuccino, [3] mocca.
- `seleccion`  in  2  — time class from the time-selection stage (combinational response).
- `ingrediente`  out  4  — ingredient code to the time-selection stage. Codes: 0001 water, 0011 coffee, 0101 milk, 0111 chocolate, 1001 sugar; 0000 when idle.
- `bebida`  out  4  — latched drink, driven to the time-selection stage.
- `valvula`  out  5  — one-hot valve enables: [0] water, [1] coffee, [2] milk, [3] chocolate, [4] sugar.
- `ocupado`  out  1  — high in every state except IDLE.
- `listo`  out  1  — one-cycle pulse when a sequence completes.
- `error`  out  1  — one-cycle pulse when a start request carries an invalid drink.

## Operation
- Reset: state IDLE, index 0. All outputs at reset: `ingrediente`=0000, `bebida`=0000, `valvula`=0, `ocupado`=0, `listo`=0, `error`=0.
- States:
  - IDLE. On `inicio` with `bebida_in` exactly one-hot: latch `bebida_in`, set index=0, go to CARGA. On `inicio` with `bebida_in` not one-hot (0000 or ≥2 bits set): `error`=1 for the next cycle, stay in IDLE.
  - CARGA. `ingrediente` shows the code for the current index, and `seleccion` is sampled in this state.
    - `seleccion`=11: skip the ingredient. Advance the index, or go to FIN after sugar.
    - Otherwise: load the counter with TICKS_x−1 and go to DISPENSA.
  - DISPENSA. `valvula[index]`=1 and all other valve bits are 0; the counter decrements each cycle. When the counter reaches 0: advance the index and go to CARGA, or go to FIN after sugar.
  - FIN. `listo`=1 for exactly one cycle, `bebida` is cleared, then IDLE.
- `cancelar` in any non-IDLE state has priority over all other transitions:
  - next cycle: IDLE, `valvula`=0, `ingrediente`=0000, `bebida`=0000;
  - no `listo` pulse.
- `cancelar` in IDLE is ignored.
- `inicio` while `ocupado`=1 is ignored, with no `error` pulse.
- `rst` during a sequence behaves like reset: valves close on the next edge.
- Registers: `ingrediente` and `valvula` are registered outputs; `ingrediente` holds its value throughout CARGA and DISPENSA of an ingredient.

## Timing
- `inicio` accepted at edge k → CARGA(water) in cycle k+1, `ocupado` high from k+1.
- Each ingredient costs 1 CARGA cycle plus N DISPENSA cycles; the valve is open for exactly N consecutive cycles.
- A skipped ingredient costs 1 CARGA cycle and never opens its valve.
- `listo` is asserted in the cycle after the last CARGA or DISPENSA cycle; `ocupado` drops one cycle after `listo`.
- `seleccion` is expected valid combinationally in the same cycle as `ingrediente`; no handshake.
- Back-to-back operation: `inicio` may be accepted in the first IDLE cycle after FIN.

## Structure
- Shared package `cafetera_pkg` holds:
  - ingredient code constants;
  - the time-class enum (CORTO=00, MEDIO=01, LARGO=10, NINGUNO=11);
  - drink bit indices;
  - the state enum {IDLE, CARGA, DISPENSA, FIN}.
- Sub-module `contador_tiempo`: loadable CNT_W-bit down-counter with `cargar`, `valor`, `habilitar` and `cero` ports.

## Test plan
- Espresso: `bebida_in`=0001 with `inicio` at cycle 0 → water valve open cycles 2–5, coffee 7–8, milk and chocolate skipped (cycles 9, 10), sugar 12–19, `listo` at cycle 20, `ocupado` covering cycles 1–20.
- Mocca: `bebida_in`=1000 → valve-open run lengths 8, 8, 8, 4, 8 in ingredient order; `listo` 42 cycles after `inicio`.
- Invalid drink: `bebida_in`=0011 with `inicio` → `error` pulse one cycle later; `ocupado`, `valvula` and `ingrediente` stay 0.
- Cancel: capuccino (0100) with `cancelar` asserted in the 3rd cycle of the coffee DISPENSA → next cycle `valvula`=0, state IDLE, no `listo`; a new `inicio` is accepted immediately afterwards.
- Ignored start and reset mid-run: `inicio` with 0010 during a running sequence is ignored (no `error`, no restart). `rst` mid-DISPENSA → all outputs at reset values on the next edge.
- Parameter sweep: TICKS_CORTO=1, TICKS_LARGO=255 with CNT_W=8 → valve open exactly 1 and 255 cycles respectively.

Source files
------------

// File: rtl/cafetera_pkg.sv
// rtl/cafetera_pkg.sv - shared constants, enums and helpers for the coffee-machine datapath
package cafetera_pkg;

    localparam logic [3:0] ING_NINGUNO   = 4'b0000;
    localparam logic [3:0] ING_AGUA      = 4'b0001;
    localparam logic [3:0] ING_CAFE      = 4'b0011;
    localparam logic [3:0] ING_LECHE     = 4'b0101;
    localparam logic [3:0] ING_CHOCOLATE = 4'b0111;
    localparam logic [3:0] ING_AZUCAR    = 4'b1001;

    localparam logic [2:0] IDX_AZUCAR = 3'd4;

    localparam int BEB_ESPRESSO   = 0;
    localparam int BEB_CAFE_LECHE = 1;
    localparam int BEB_CAPUCCINO  = 2;
    localparam int BEB_MOCCA      = 3;

    typedef enum logic [1:0] {
        CORTO   = 2'b00,
        MEDIO   = 2'b01,
        LARGO   = 2'b10,
        NINGUNO = 2'b11
    } clase_tiempo_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CARGA    = 2'd1,
        DISPENSA = 2'd2,
        FIN      = 2'd3
    } estado_t;

    function automatic logic [3:0] codigo_ingrediente(input logic [2:0] idx);
        case (idx)
            3'd0:    return ING_AGUA;
            3'd1:    return ING_CAFE;
            3'd2:    return ING_LECHE;
            3'd3:    return ING_CHOCOLATE;
            3'd4:    return ING_AZUCAR;
            default: return ING_NINGUNO;
        endcase
    endfunction

    function automatic logic es_onehot(input logic [3:0] b);
        return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/contador_tiempo.sv
// rtl/contador_tiempo.sv - loadable down-counter timing how long a valve stays open
module contador_tiempo #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cargar,
    input  logic [CNT_W-1:0] valor,
    input  logic             habilitar,
    output logic             cero
);

    logic [CNT_W-1:0] cuenta;

    // Saturates at zero so a stray enable never wraps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= valor;
        end else if (habilitar && (cuenta != '0)) begin
            cuenta <= cuenta - 1'b1;
        end
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/control_dispensado.sv
// rtl/control_dispensado.sv - sequences water/coffee/milk/chocolate/sugar valves for one drink
module control_dispensado
    import cafetera_pkg::*;
#(
    parameter int TICKS_CORTO = 2,
    parameter int TICKS_MEDIO = 4,
    parameter int TICKS_LARGO = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
    input  logic       cancelar,
    input  logic [3:0] bebida_in,
    input  logic [1:0] seleccion,
    output logic [3:0] ingrediente,
    output logic [3:0] bebida,
    output logic [4:0] valvula,
    output logic       ocupado,
    output logic       listo,
    output logic       error
);

    localparam logic [CNT_W-1:0] CUENTA_CORTO = CNT_W'(TICKS_CORTO - 1);
    localparam logic [CNT_W-1:0] CUENTA_MEDIO = CNT_W'(TICKS_MEDIO - 1);
    localparam logic [CNT_W-1:0] CUENTA_LARGO = CNT_W'(TICKS_LARGO - 1);

    estado_t          estado, estado_sig;
    logic [2:0]       idx, idx_sig;
    logic [3:0]       bebida_sig, ingrediente_sig;
    logic [4:0]       valvula_sig;
    logic             error_sig;
    logic             cargar, cero;
    logic [CNT_W-1:0] valor_carga;

    contador_tiempo #(.CNT_W(CNT_W)) u_contador (
        .clk       (clk),
        .rst       (rst),
        .cargar    (cargar),
        .valor     (valor_carga),
        .habilitar (estado == DISPENSA),
        .cero      (cero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= IDLE;
            idx         <= 3'd0;
            bebida      <= 4'b0000;
            ingrediente <= ING_NINGUNO;
            valvula     <= 5'b00000;
            error       <= 1'b0;
        end else begin
            estado      <= estado_sig;
            idx         <= idx_sig;
            bebida      <= bebida_sig;
            ingrediente <= ingrediente_sig;
            valvula     <= valvula_sig;
            error       <= error_sig;
        end
    end

    always_comb begin
        estado_sig  = estado;
        idx_sig     = idx;
        bebida_sig  = bebida;
        error_sig   = 1'b0;
        cargar      = 1'b0;
        valor_carga = '0;

        case (estado)
            IDLE: begin
                if (inicio) begin
                    if (es_onehot(bebida_in)) begin
                        bebida_sig = bebida_in;
                        idx_sig    = 3'd0;
                        estado_sig = CARGA;
                    end else begin
                        error_sig = 1'b1;
                    end
                end
            end
            CARGA: begin
                if (clase_tiempo_t'(seleccion) == NINGUNO) begin
                    if (idx == IDX_AZUCAR) estado_sig = FIN;
                    else                   idx_sig    = idx + 3'd1;
                end else begin
                    cargar     = 1'b1;
                    estado_sig = DISPENSA;
                    case (clase_tiempo_t'(seleccion))
                        CORTO:   valor_carga = CUENTA_CORTO;
                        MEDIO:   valor_carga = CUENTA_MEDIO;
                        default: valor_carga = CUENTA_LARGO;
                    endcase
                end
            end
            DISPENSA: begin
                if (cero) begin
                    if (idx == IDX_AZUCAR) begin
                        estado_sig = FIN;
                    end else begin
                        idx_sig    = idx + 3'd1;
                        estado_sig = CARGA;
                    end
                end
            end
            default: begin
                bebida_sig = 4'b0000;
                estado_sig = IDLE;
            end
        endcase

        // Abort wins over every other transition once a sequence is running.
        if (cancelar && (estado != IDLE)) begin
            estado_sig = IDLE;
            bebida_sig = 4'b0000;
            cargar     = 1'b0;
        end

        // Outputs are registered, so they are computed from the upcoming state.
        ingrediente_sig = ((estado_sig == CARGA) || (estado_sig == DISPENSA))
                          ? codigo_ingrediente(idx_sig) : ING_NINGUNO;
        valvula_sig     = (estado_sig == DISPENSA) ? (5'b00001 << idx_sig) : 5'b00000;
    end

    assign ocupado = (estado != IDLE);
    assign listo   = (estado == FIN);

endmodule

// File: tb/tb_control_dispensado.sv
// tb/tb_control_dispensado.sv - directed table-driven bench for control_dispensado
module tb_control_dispensado;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, inicio, cancelar;
    logic [3:0] bebida_in, ingrediente, bebida;
    logic [1:0] seleccion;
    logic [4:0] valvula;
    logic       ocupado, listo, error;

    logic       inicio_p, cancelar_p;
    logic [3:0] bebida_in_p, ingrediente_p, bebida_p;
    logic [1:0] seleccion_p;
    logic [4:0] valvula_p;
    logic       ocupado_p, listo_p, error_p;

    int pasados = 0;
    int total   = 0;

    int runs [5];
    int nruns[5];
    int ciclo_listo;
    bit onehot_ok;

    // Time-selection stage: per drink, classes packed {sugar,choc,milk,coffee,water}.
    function automatic logic [1:0] modelo_sel(input logic [3:0] ing, input logic [3:0] beb);
        logic [9:0] t;
        int         i;
        case (ing)
            4'b0001: i = 0;
            4'b0011: i = 1;
            4'b0101: i = 2;
            4'b0111: i = 3;
            4'b1001: i = 4;
            default: return 2'b11;
        endcase
        case (beb)
            4'b0001: t = 10'b10_11_11_00_01;
            4'b0010: t = 10'b11_11_10_00_00;
            4'b0100: t = 10'b00_11_10_01_01;
            4'b1000: t = 10'b10_01_10_10_10;
            default: t = 10'b11_11_11_11_11;
        endcase
        return t[2*i +: 2];
    endfunction

    assign seleccion   = modelo_sel(ingrediente, bebida);
    assign seleccion_p = modelo_sel(ingrediente_p, bebida_p);

    control_dispensado dut (
        .clk(clk), .rst(rst), .inicio(inicio), .cancelar(cancelar),
        .bebida_in(bebida_in), .seleccion(seleccion), .ingrediente(ingrediente),
        .bebida(bebida), .valvula(valvula), .ocupado(ocupado), .listo(listo), .error(error)
    );

    control_dispensado #(.TICKS_CORTO(1), .TICKS_MEDIO(4), .TICKS_LARGO(255), .CNT_W(8)) dut_p (
        .clk(clk), .rst(rst), .inicio(inicio_p), .cancelar(cancelar_p),
        .bebida_in(bebida_in_p), .seleccion(seleccion_p), .ingrediente(ingrediente_p),
        .bebida(bebida_p), .valvula(valvula_p), .ocupado(ocupado_p), .listo(listo_p), .error(error_p)
    );

    typedef struct {
        logic       ini;
        logic       can;
        logic [3:0] beb;
        logic [3:0] ing;
        logic [4:0] val;
        logic [3:0] bsal;
        logic       ocu;
        logic       lis;
        logic       err;
    } vec_t;

    vec_t tabla[$];

    task automatic agregar(input int n, input logic ini, input logic can, input logic [3:0] beb,
                           input logic [3:0] ing, input logic [4:0] val, input logic [3:0] bsal,
                           input logic ocu, input logic lis, input logic err);
        vec_t v;
        v.ini = ini; v.can = can; v.beb = beb; v.ing = ing; v.val = val;
        v.bsal = bsal; v.ocu = ocu; v.lis = lis; v.err = err;
        repeat (n) tabla.push_back(v);
    endtask

    task automatic check(input string nombre, input logic [31:0] real_v, input logic [31:0] esperado);
        total++;
        if (real_v === esperado) pasados++;
        else $display("FAIL %s: got %0h expected %0h", nombre, real_v, esperado);
    endtask

    // Starts a drink at the current cycle (0) and records valve runs and the listo cycle.
    task automatic medir(input bit usa_p, input logic [3:0] beb, input int limite);
        logic [4:0] v, prev;
        logic       l;
        for (int b = 0; b < 5; b++) begin runs[b] = 0; nruns[b] = 0; end
        ciclo_listo = -1;
        onehot_ok   = 1'b1;
        prev        = 5'b0;
        if (usa_p) begin inicio_p = 1'b1; bebida_in_p = beb; end
        else       begin inicio   = 1'b1; bebida_in   = beb; end
        for (int c = 1; c <= limite; c++) begin
            @(posedge clk); #1;
            inicio = 1'b0; bebida_in = 4'b0; inicio_p = 1'b0; bebida_in_p = 4'b0;
            @(negedge clk);
            v = usa_p ? valvula_p : valvula;
            l = usa_p ? listo_p : listo;
            for (int b = 0; b < 5; b++) begin
                if (v[b]) begin
                    runs[b]++;
                    if (!prev[b]) nruns[b]++;
                end
            end
            if ($countones(v) > 1) onehot_ok = 1'b0;
            if (l && (ciclo_listo < 0)) ciclo_listo = c;
            prev = v;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_mocca[5];
        int exp_p[5];
        exp_mocca = '{8, 8, 8, 4, 8};
        exp_p     = '{4, 1, 0, 0, 255};

        // Espresso, cycle by cycle; an ignored start at cycle 4 and a cancel in IDLE at cycle 21.
        agregar(1, 1, 0, 4'b0001, 4'b0000, 5'b00000, 4'b0000, 0, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0001, 5'b00000, 4'b0001, 1, 0, 0);
        agregar(2, 0, 0, 4'b0000, 4'b0001, 5'b00001, 4'b0001, 1, 0, 0);
        agregar(1, 1, 0, 4'b0010, 4'b0001, 5'b00001, 4'b0001, 1, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0001, 5'b00001, 4'b0001, 1, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0011, 5'b00000, 4'b0001, 1, 0, 0);
        agregar(2, 0, 0, 4'b0000, 4'b0011, 5'b00010, 4'b0001, 1, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0101, 5'b00000, 4'b0001, 1, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0111, 5'b00000, 4'b0001, 1, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b1001, 5'b00000, 4'b0001, 1, 0, 0);
        agregar(8, 0, 0, 4'b0000, 4'b1001, 5'b10000, 4'b0001, 1, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0001, 1, 1, 0);
        agregar(1, 0, 1, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 0, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 0, 0, 0);
        // Invalid drinks: two bits set, then none.
        agregar(1, 1, 0, 4'b0011, 4'b0000, 5'b00000, 4'b0000, 0, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 0, 0, 1);
        agregar(1, 1, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 0, 0, 0);
        agregar(1, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 0, 0, 1);
        agregar(1, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 0, 0, 0);

        rst = 1'b1; inicio = 1'b0; cancelar = 1'b0; bebida_in = 4'b0;
        inicio_p = 1'b0; cancelar_p = 1'b0; bebida_in_p = 4'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", {ingrediente, valvula, bebida, ocupado, listo, error}, 32'h0);
        check("reset_p", {ingrediente_p, valvula_p, bebida_p, ocupado_p, listo_p, error_p}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tabla.size(); i++) begin
            inicio = tabla[i].ini; cancelar = tabla[i].can; bebida_in = tabla[i].beb;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {ingrediente, valvula, bebida, ocupado, listo, error},
                  {tabla[i].ing, tabla[i].val, tabla[i].bsal, tabla[i].ocu, tabla[i].lis, tabla[i].err});
            @(posedge clk); #1;
        end
        inicio = 1'b0; cancelar = 1'b0; bebida_in = 4'b0;

        // Capuccino cancelled in the 3rd coffee cycle, then a latte accepted at once.
        inicio = 1'b1; bebida_in = 4'b0100;
        @(posedge clk); #1;
        inicio = 1'b0; bebida_in = 4'b0;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("cancel_pre_valve", valvula, 5'b00010);
        cancelar = 1'b1;
        @(posedge clk); #1;
        cancelar = 1'b0; inicio = 1'b1; bebida_in = 4'b0010;
        @(negedge clk);
        check("cancel_outputs", {ingrediente, valvula, bebida, ocupado, listo}, 32'h0);
        @(posedge clk); #1;
        inicio = 1'b0; bebida_in = 4'b0;
        @(negedge clk);
        check("restart_after_cancel", {ingrediente, bebida, ocupado}, {4'b0001, 4'b0010, 1'b1});

        // Reset in the middle of the latte water dispense.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_valve", valvula, 5'b00001);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_midrun", {ingrediente, valvula, bebida, ocupado, listo, error}, 32'h0);
        @(posedge clk); #1;

        medir(1'b0, 4'b1000, 60);
        for (int b = 0; b < 5; b++) begin
            check($sformatf("mocca_run%0d", b), runs[b], exp_mocca[b]);
            check($sformatf("mocca_nruns%0d", b), nruns[b], 1);
        end
        check("mocca_listo_cycle", ciclo_listo, 42);
        check("mocca_onehot", onehot_ok, 1);
        check("mocca_idle_after", {ocupado, bebida, valvula}, 32'h0);

        medir(1'b1, 4'b0001, 300);
        for (int b = 0; b < 5; b++) begin
            check($sformatf("sweep_run%0d", b), runs[b], exp_p[b]);
            check($sformatf("sweep_nruns%0d", b), nruns[b], (exp_p[b] != 0) ? 1 : 0);
        end
        check("sweep_listo_cycle", ciclo_listo, 266);
        check("sweep_idle_after", {ocupado_p, bebida_p, error_p}, 32'h0);

        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule
